carry_skip_16bit: RTL and testbench

CARRY_SKIP_16BIT -- requirements
Module: carry_skip_16bit

---
 rtl/carry_skip_16bit_pkg.sv | 7 +
 rtl/carry_skip_16bit_cskip_block.sv | 36 +++
 rtl/carry_skip_16bit.sv | 99 +++++++++
 tb/tb_carry_skip_16bit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/carry_skip_16bit_pkg.sv
// Shared constants for the 16-bit carry-skip adder.
package carry_skip_pkg;

  localparam int ADD_W           = 16;
  localparam int DEFAULT_BLOCK_W = 4;

endpackage

// File: rtl/carry_skip_16bit_cskip_block.sv
// One carry-skip block: W-bit ripple adder whose carry-out is bypassed by the
// block carry-in whenever every bit in the block propagates.
module cskip_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] prop_bit;
  logic         block_prop;
  logic         ripple_cout;

  assign prop_bit = a_i ^ b_i;

  // Per-bit carries live in their own generate scopes so the chain is not one self-referencing vector.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic c_in;
    logic c_out;
    if (gi == 0) begin : g_first
      assign c_in = cin_i;
    end else begin : g_next
      assign c_in = g_bit[gi-1].c_out;
    end
    assign sum_o[gi] = prop_bit[gi] ^ c_in;
    assign c_out     = (a_i[gi] & b_i[gi]) | (prop_bit[gi] & c_in);
  end

  assign ripple_cout = g_bit[W-1].c_out;
  assign block_prop  = &prop_bit;
  assign cout_o      = block_prop ? cin_i : ripple_cout;

endmodule

// File: rtl/carry_skip_16bit.sv
// Registered 16-bit carry-skip adder, one result per cycle, one-cycle latency.
// Optional signed-overflow output enabled by defining CARRY_SKIP_OVF_EN.
module carry_skip_16bit
  import carry_skip_pkg::*;
#(
  parameter int BLOCK_W = DEFAULT_BLOCK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout,
`ifdef CARRY_SKIP_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int NUM_BLK = ADD_W / BLOCK_W;

  logic [ADD_W-1:0] sum_comb;
  logic             cout_comb;

  for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
    logic blk_cin;
    logic blk_cout;
    if (gi == 0) begin : g_first
      assign blk_cin = cin;
    end else begin : g_next
      assign blk_cin = g_blk[gi-1].blk_cout;
    end
    cskip_block #(.W(BLOCK_W)) u_block (
      .a_i    (a[gi*BLOCK_W +: BLOCK_W]),
      .b_i    (b[gi*BLOCK_W +: BLOCK_W]),
      .cin_i  (blk_cin),
      .sum_o  (sum_comb[gi*BLOCK_W +: BLOCK_W]),
      .cout_o (blk_cout)
    );
  end

  assign cout_comb = g_blk[NUM_BLK-1].blk_cout;

  logic [ADD_W-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_comb;
      cout_d  = cout_comb;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

`ifdef CARRY_SKIP_OVF_EN
  logic ovf_q, ovf_d;

  // Like-signed operands producing an opposite-signed result overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = (a[ADD_W-1] == b[ADD_W-1]) && (sum_comb[ADD_W-1] != a[ADD_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_skip_16bit.sv
// Scoreboard bench for carry_skip_16bit: three instances (BLOCK_W = 2, 4, 8) share stimulus
// and are checked against an arithmetic reference. Define CARRY_SKIP_OVF_EN to check ovf too.
module tb_carry_skip_16bit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;

  logic [15:0] sum_w   [3];
  logic        cout_w  [3];
  logic        valid_w [3];
  logic        ovf_w   [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    carry_skip_16bit #(.BLOCK_W(2 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum_w[gi]),
      .cout      (cout_w[gi]),
`ifdef CARRY_SKIP_OVF_EN
      .ovf       (ovf_w[gi]),
`endif
      .out_valid (valid_w[gi])
    );
`ifndef CARRY_SKIP_OVF_EN
    assign ovf_w[gi] = 1'b0;
`endif
  end

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   n_tx       = 0;

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    exp_t        r;
    logic [16:0] tot;
    int          ssum;
    tot  = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
    ssum = $signed({{16{ta[15]}}, ta}) + $signed({{16{tb_v[15]}}, tb_v}) + int'(tc);
    r.s  = tot[15:0];
    r.c  = tot[16];
    r.v  = (ssum > 32767) || (ssum < -32768);
    return r;
  endfunction

  task automatic check(input string name, input int k, input logic [16:0] act, input logic [16:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s (BLOCK_W=%0d) @%0t: got 0x%0h, expected 0x%0h", name, 2 << k, $time, act, req);
    end
  endtask

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    exp_q.push_back(model(ta, tb_v, tc));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom);
    end
  endtask

  // Bench-side expectation of what the DUT saw at each edge.
  logic exp_valid = 1'b0;
  logic rst_seen  = 1'b0;
  logic mon_en    = 1'b0;

  always @(posedge clk) begin
    exp_valid <= in_valid && !rst;
    rst_seen  <= rst;
    mon_en    <= 1'b1;
  end

  exp_t held = '0;

  always @(negedge clk) begin
    exp_t cur;
    if (mon_en) begin
      if (rst_seen) held = '0;
      cur = held;
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_underflow @%0t: got result, expected none queued", $time);
        end else begin
          cur  = exp_q.pop_front();
          held = cur;
          if (n_tx < 16)
            $display("tx %0d: sum=0x%04h cout=%0b (expected)", n_tx, cur.s, cur.c);
          n_tx++;
        end
      end
      for (int k = 0; k < 3; k++) begin
        check("out_valid", k, {16'd0, valid_w[k]}, {16'd0, exp_valid});
        check("sum",       k, {1'b0, sum_w[k]},    {1'b0, cur.s});
        check("cout",      k, {16'd0, cout_w[k]},  {16'd0, cur.c});
`ifdef CARRY_SKIP_OVF_EN
        check("ovf",       k, {16'd0, ovf_w[k]},   {16'd0, cur.v});
`endif
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    repeat (3) @(posedge clk);

    issue(16'h0005, 16'h0005, 1'b1);
    issue(16'h001F, 16'h000C, 1'b0);
    issue(16'hC61F, 16'h018C, 1'b1);
    issue(16'hFFFF, 16'h0000, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0);
    idle(2);
    issue(16'h0001, 16'h0001, 1'b1);
    issue(16'h0002, 16'h0002, 1'b1);
    idle(1);

    // Reset with a live operand: it must be discarded, then outputs hold.
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    idle(3);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle(1);
      end else begin
        ra = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ~ra;
          1:       rb = ~ra ^ (16'h1 << $urandom_range(0, 15));
          default: rb = 16'($urandom);
        endcase
        issue(ra, rb, 1'($urandom));
      end
    end
    idle(3);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
